ram16x4_ctrl: RTL and testbench



---
 rtl/ram16x4_pkg.sv | 18 +
 rtl/ram16x4_ctrl.sv | 112 +++++++++++
 tb/tb_ram16x4_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram16x4_pkg.sv
// Shared definitions for the 16x4 asynchronous RAM and its synchronous initiator.
package ram16x4_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 4;
    localparam int RAM_DEPTH  = 16;

    // Width of the phase counter that times setup, access and hold.
    localparam int PH_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/ram16x4_ctrl.sv
// Synchronous initiator for the 16x4 asynchronous RAM.
// Accepts one read or write at a time over valid/ready.
// Each transaction walks through three phases:
//   SETUP  - address and data are driven while the RAM is deselected
//   ACCESS - the chip select strobe is active
//   HOLD   - address and data stay put after deselect
// A read returns its data as a single-cycle rsp_valid pulse.
// Every output is a flop, so no input reaches an output combinationally.
module ram16x4_ctrl
    import ram16x4_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [RAM_ADDR_W-1:0] req_addr,
    input  logic [RAM_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [RAM_DATA_W-1:0] rsp_rdata,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [RAM_DATA_W-1:0] ram_datain,
    output logic                  ram_csn,
    output logic                  ram_rwn,
    input  logic [RAM_DATA_W-1:0] ram_dataout
);

    // The counter is loaded with N-1 on entry and the phase ends when it reaches zero,
    // so each phase lasts exactly N cycles.
    localparam logic [PH_W-1:0] SETUP_LD = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] PULSE_LD = PH_W'(PULSE_CYC - 1);
    localparam logic [PH_W-1:0] HOLD_LD  = PH_W'(HOLD_CYC - 1);

    ctrl_state_t     state;
    logic [PH_W-1:0] cnt;
    logic            op_we;

    // Phase sequencer. Strobes, handshake and response are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_we      <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            ram_addr   <= '0;
            ram_datain <= '0;
            ram_csn    <= 1'b1;
            ram_rwn    <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        // Address and data are latched only here, so they cannot
                        // move while the RAM is selected.
                        op_we      <= req_we;
                        ram_addr   <= req_addr;
                        ram_datain <= req_wdata;
                        req_ready  <= 1'b0;
                        cnt        <= SETUP_LD;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        ram_csn <= 1'b0;
                        ram_rwn <= ~op_we;
                        cnt     <= PULSE_LD;
                        state   <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        // Capture read data at the end of the strobe,
                        // just before deselecting the RAM.
                        if (!op_we) begin
                            rsp_rdata <= ram_dataout;
                            rsp_valid <= 1'b1;
                        end
                        ram_csn <= 1'b1;
                        ram_rwn <= 1'b1;
                        cnt     <= HOLD_LD;
                        state   <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram16x4_ctrl.sv
// Directed bench for ram16x4_ctrl, with a behavioural 16x4 RAM as its load.
module tb_ram16x4_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_valid2 = 1'b0;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = 4'h0;
    logic [3:0] req_wdata = 4'h0;

    logic       req_ready, rsp_valid, ram_csn, ram_rwn;
    logic [3:0] rsp_rdata, ram_addr, ram_datain;
    wire  [3:0] ram_dataout;

    logic       req_ready2, rsp_valid2, ram_csn2, ram_rwn2;
    logic [3:0] rsp_rdata2, ram_addr2, ram_datain2;
    wire  [3:0] ram_dataout2;

    int nvec = 0;
    int nmis = 0;

    logic [3:0] mem [16];
    logic [3:0] exp_mem [16];

    always #5 clk = ~clk;

    ram16x4_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_datain(ram_datain),
        .ram_csn(ram_csn), .ram_rwn(ram_rwn), .ram_dataout(ram_dataout)
    );

    ram16x4_ctrl #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
        .ram_addr(ram_addr2), .ram_datain(ram_datain2),
        .ram_csn(ram_csn2), .ram_rwn(ram_rwn2), .ram_dataout(ram_dataout2)
    );

    // Behavioural RAM: writes while selected in write mode; reads drive the bus,
    // which floats otherwise.
    always @(posedge clk) begin
        if (!ram_csn && !ram_rwn) mem[ram_addr] <= ram_datain;
    end
    assign ram_dataout  = (!ram_csn && ram_rwn) ? mem[ram_addr] : 4'bz;

    // Fixed-pattern load for the second instance: location a reads back a ^ 5.
    assign ram_dataout2 = (!ram_csn2 && ram_rwn2) ? (ram_addr2 ^ 4'h5) : 4'bz;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Protocol monitor on the default instance.
    logic       prev_csn = 1'b1;
    logic [3:0] prev_addr = 4'h0;
    logic [3:0] prev_din = 4'h0;
    int         gap = 0;
    logic       had_acc = 1'b0;

    always @(negedge clk) begin
        chk("rwn_low_while_desel", {7'b0, (!ram_rwn && ram_csn)}, 8'd0);
        if (!prev_csn && !ram_csn) begin
            chk("addr_stable", {4'b0, ram_addr}, {4'b0, prev_addr});
            chk("din_stable", {4'b0, ram_datain}, {4'b0, prev_din});
        end
        if (!rst_n) begin
            had_acc <= 1'b0;
            gap     <= 0;
        end else if (ram_csn) begin
            gap <= gap + 1;
        end else begin
            if (prev_csn && had_acc) chk("csn_gap_ge_2", {7'b0, gap >= 2}, 8'd1);
            had_acc <= 1'b1;
            gap     <= 0;
        end
        prev_csn  <= ram_csn;
        prev_addr <= ram_addr;
        prev_din  <= ram_datain;
    end

    // One full transaction on the default instance. Call just after a negedge;
    // returns at the negedge where req_ready is seen high again.
    task automatic op(input logic we, input logic [3:0] a, input logic [3:0] d,
                      output int k_rsp, output int n_rsp, output int n_nrdy,
                      output int n_rwn0, output int k_rdy, output logic [3:0] rd);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("ready_timeout", 8'd0, 8'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k_rsp = 0; n_rsp = 0; n_nrdy = 0; n_rwn0 = 0; k_rdy = 0;
        for (int k = 1; k <= 40 && k_rdy == 0; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n_rsp++;
                if (k_rsp == 0) k_rsp = k;
            end
            if (!ram_rwn) n_rwn0++;
            if (req_ready) k_rdy = k;
            else n_nrdy++;
        end
        rd = rsp_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         k_rsp, n_rsp, n_nrdy, n_rwn0, k_rdy;
        logic [3:0] rd;
        logic       we;
        logic [3:0] a, d;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_csn", {7'b0, ram_csn}, 8'd1);
        chk("rst_rwn", {7'b0, ram_rwn}, 8'd1);
        chk("rst_ready", {7'b0, req_ready}, 8'd0);
        chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'd0);
        chk("rst_addr", {4'b0, ram_addr}, 8'd0);
        chk("rst_rdata", {4'b0, rsp_rdata}, 8'd0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", {7'b0, req_ready}, 8'd0);
        @(negedge clk);
        chk("ready_after_edge", {7'b0, req_ready}, 8'd1);

        // Single write then read
        op(1'b1, 4'h3, 4'hA, k_rsp, n_rsp, n_nrdy, n_rwn0, k_rdy, rd);
        exp_mem[3] = 4'hA;
        chk("wr_no_rsp", 8'(n_rsp), 8'd0);
        chk("wr_rwn0_cycles", 8'(n_rwn0), 8'd2);
        chk("wr_ready_back", 8'(k_rdy), 8'd5);
        op(1'b0, 4'h3, 4'h0, k_rsp, n_rsp, n_nrdy, n_rwn0, k_rdy, rd);
        chk("rd_rsp_latency", 8'(k_rsp), 8'd4);
        chk("rd_rsp_count", 8'(n_rsp), 8'd1);
        chk("rd_data_3", {4'b0, rd}, 8'h0A);
        chk("rd_rwn0_cycles", 8'(n_rwn0), 8'd0);

        // Fill all locations back-to-back, then read them all back
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 4'(i), 4'(i) ^ 4'hF, k_rsp, n_rsp, n_nrdy, n_rwn0, k_rdy, rd);
            exp_mem[i] = 4'(i) ^ 4'hF;
            chk("fill_nrdy", 8'(n_nrdy), 8'd4);
            chk("fill_rwn0", 8'(n_rwn0), 8'd2);
        end
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 4'(i), 4'h0, k_rsp, n_rsp, n_nrdy, n_rwn0, k_rdy, rd);
            chk("fill_rd_data", {4'b0, rd}, {4'b0, 4'(i) ^ 4'hF});
            chk("fill_rd_lat", 8'(k_rsp), 8'd4);
            chk("fill_nrdy_rd", 8'(n_nrdy), 8'd4);
        end

        // Random traffic against a scoreboard; the monitor watches the RAM pins
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = 4'($urandom_range(0, 15));
            op(we, a, d, k_rsp, n_rsp, n_nrdy, n_rwn0, k_rdy, rd);
            if (we) begin
                exp_mem[a] = d;
                chk("rnd_wr_no_rsp", 8'(n_rsp), 8'd0);
            end else begin
                chk("rnd_rd_data", {4'b0, rd}, {4'b0, exp_mem[a]});
                chk("rnd_rd_count", 8'(n_rsp), 8'd1);
            end
        end

        // Reset during the second access cycle of a read
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'h5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_csn_active", {7'b0, ram_csn}, 8'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_csn", {7'b0, ram_csn}, 8'd1);
        chk("mid_rst_rwn", {7'b0, ram_rwn}, 8'd1);
        chk("mid_rst_ready", {7'b0, req_ready}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", {7'b0, rsp_valid}, 8'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_ready_back", {7'b0, req_ready}, 8'd1);
        op(1'b0, 4'h9, 4'h0, k_rsp, n_rsp, n_nrdy, n_rwn0, k_rdy, rd);
        chk("post_rst_data", {4'b0, rd}, {4'b0, exp_mem[9]});
        chk("post_rst_lat", 8'(k_rsp), 8'd4);

        // Second instance with S=3, P=1, H=2: read location 6
        k_rsp = 0; k_rdy = 0; n_rsp = 0;
        chk("sw_ready_idle", {7'b0, req_ready2}, 8'd1);
        req_valid2 = 1'b1;
        req_we     = 1'b0;
        req_addr   = 4'h6;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        for (int k = 1; k <= 20 && k_rdy == 0; k++) begin
            @(negedge clk);
            if (rsp_valid2) begin
                n_rsp++;
                if (k_rsp == 0) k_rsp = k;
            end
            if (req_ready2) k_rdy = k;
        end
        chk("sw_rsp_latency", 8'(k_rsp), 8'd5);
        chk("sw_rsp_count", 8'(n_rsp), 8'd1);
        chk("sw_ready_back", 8'(k_rdy), 8'd7);
        chk("sw_rd_data", {4'b0, rsp_rdata2}, 8'h03);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
